// File: rtl/axi4_lite_master_pkg.sv
// Shared types for the AXI4-Lite initiator: response codes and FSM states.
package axi4_lite_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WR    = 3'd1,
    S_WRESP = 3'd2,
    S_RD_A  = 3'd3,
    S_RD_D  = 3'd4,
    S_RSP   = 3'd5
  } state_t;

  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axi4_lite_master_if.sv
// AXI4-Lite bus bundle between the initiator (master) and a register slave.
interface axi4_lite_master_if #(
  parameter int ADDRESS    = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDRESS-1:0]      M_AWADDR;
  logic                    M_AWVALID;
  logic                    M_AWREADY;
  logic [DATA_WIDTH-1:0]   M_WDATA;
  logic [DATA_WIDTH/8-1:0] M_WSTRB;
  logic                    M_WVALID;
  logic                    M_WREADY;
  logic [1:0]              M_BRESP;
  logic                    M_BVALID;
  logic                    M_BREADY;
  logic [ADDRESS-1:0]      M_ARADDR;
  logic                    M_ARVALID;
  logic                    M_ARREADY;
  logic [DATA_WIDTH-1:0]   M_RDATA;
  logic [1:0]              M_RRESP;
  logic                    M_RVALID;
  logic                    M_RREADY;

  modport master (
    output M_AWADDR, M_AWVALID, M_WDATA, M_WSTRB, M_WVALID, M_BREADY,
           M_ARADDR, M_ARVALID, M_RREADY,
    input  M_AWREADY, M_WREADY, M_BRESP, M_BVALID, M_ARREADY,
           M_RDATA, M_RRESP, M_RVALID
  );

  modport slave (
    input  M_AWADDR, M_AWVALID, M_WDATA, M_WSTRB, M_WVALID, M_BREADY,
           M_ARADDR, M_ARVALID, M_RREADY,
    output M_AWREADY, M_WREADY, M_BRESP, M_BVALID, M_ARREADY,
           M_RDATA, M_RRESP, M_RVALID
  );
endinterface

// File: rtl/axi4_lite_master.sv
// Single-outstanding AXI4-Lite initiator: one command in, one AXI transaction,
// one response out. Optional response-wait timeout: AXI4L_MASTER_TIMEOUT_EN.
module axi4_lite_master
  import axi4_lite_pkg::*;
#(
  parameter int ADDRESS        = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDRESS-1:0]      cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
  output logic                    rsp_timeout,
  axi4_lite_master_if.master      m_axi
);

  localparam int SW = DATA_WIDTH / 8;
  // Word-aligned addressing: low two address bits are always driven as zero.
  localparam logic [ADDRESS-1:0] ALIGN_MASK = ~{{(ADDRESS-2){1'b0}}, 2'b11};

  state_t                state_q, state_d;
  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q, wvalid_d;
  logic                  bready_q, bready_d;
  logic                  arvalid_q, arvalid_d;
  logic                  rready_q, rready_d;
  logic [ADDRESS-1:0]    awaddr_q, awaddr_d;
  logic [ADDRESS-1:0]    araddr_q, araddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [SW-1:0]         wstrb_q, wstrb_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [1:0]            rsp_resp_q, rsp_resp_d;
  logic                  aw_done, w_done;

`ifdef AXI4L_MASTER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rsp_timeout_q, rsp_timeout_d;
  logic          expired;
`endif

  // Next-state and registered-output computation for the transaction FSM.
  always_comb begin
    state_d     = state_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    awaddr_d    = awaddr_q;
    araddr_d    = araddr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;
    aw_done     = !awvalid_q || m_axi.M_AWREADY;
    w_done      = !wvalid_q || m_axi.M_WREADY;
`ifdef AXI4L_MASTER_TIMEOUT_EN
    cnt_d         = cnt_q;
    rsp_timeout_d = rsp_timeout_q;
    expired       = (cnt_q == CW'(TIMEOUT_CYCLES - 1));
`endif
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          if (cmd_write) begin
            awaddr_d  = cmd_addr & ALIGN_MASK;
            wdata_d   = cmd_wdata;
            wstrb_d   = cmd_wstrb;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = S_WR;
          end else begin
            araddr_d  = cmd_addr & ALIGN_MASK;
            arvalid_d = 1'b1;
            state_d   = S_RD_A;
          end
        end
      end
      S_WR: begin
        // AW and W complete independently; move on once both have handshaken.
        if (awvalid_q && m_axi.M_AWREADY) awvalid_d = 1'b0;
        if (wvalid_q && m_axi.M_WREADY)   wvalid_d  = 1'b0;
        if (aw_done && w_done) begin
          bready_d = 1'b1;
          state_d  = S_WRESP;
`ifdef AXI4L_MASTER_TIMEOUT_EN
          cnt_d    = '0;
`endif
        end
      end
      S_WRESP: begin
        if (m_axi.M_BVALID) begin
          bready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_resp_d  = m_axi.M_BRESP;
          rsp_rdata_d = '0;
          state_d     = S_RSP;
`ifdef AXI4L_MASTER_TIMEOUT_EN
          rsp_timeout_d = 1'b0;
        end else if (expired) begin
          bready_d      = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_resp_d    = RESP_SLVERR;
          rsp_rdata_d   = '0;
          rsp_timeout_d = 1'b1;
          state_d       = S_RSP;
        end else begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      S_RD_A: begin
        if (m_axi.M_ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = S_RD_D;
`ifdef AXI4L_MASTER_TIMEOUT_EN
          cnt_d     = '0;
`endif
        end
      end
      S_RD_D: begin
        if (m_axi.M_RVALID) begin
          rready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_resp_d  = m_axi.M_RRESP;
          rsp_rdata_d = m_axi.M_RDATA;
          state_d     = S_RSP;
`ifdef AXI4L_MASTER_TIMEOUT_EN
          rsp_timeout_d = 1'b0;
        end else if (expired) begin
          rready_d      = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_resp_d    = RESP_SLVERR;
          rsp_rdata_d   = '0;
          rsp_timeout_d = 1'b1;
          state_d       = S_RSP;
        end else begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      S_RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset drops any in-flight transaction.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q     <= S_IDLE;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      awaddr_q    <= '0;
      araddr_q    <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= '0;
    end else begin
      state_q     <= state_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      awaddr_q    <= awaddr_d;
      araddr_q    <= araddr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
    end
  end

`ifdef AXI4L_MASTER_TIMEOUT_EN
  // Response-wait counter and timeout flag.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      cnt_q         <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end
  assign rsp_timeout = rsp_timeout_q;
`else
  assign rsp_timeout = 1'b0;
`endif

  // cmd_ready is the only combinational output; held low while in reset.
  assign cmd_ready       = (state_q == S_IDLE) && ARESETN;
  assign rsp_valid       = rsp_valid_q;
  assign rsp_rdata       = rsp_rdata_q;
  assign rsp_resp        = rsp_resp_q;
  assign m_axi.M_AWADDR  = awaddr_q;
  assign m_axi.M_AWVALID = awvalid_q;
  assign m_axi.M_WDATA   = wdata_q;
  assign m_axi.M_WSTRB   = wstrb_q;
  assign m_axi.M_WVALID  = wvalid_q;
  assign m_axi.M_BREADY  = bready_q;
  assign m_axi.M_ARADDR  = araddr_q;
  assign m_axi.M_ARVALID = arvalid_q;
  assign m_axi.M_RREADY  = rready_q;

endmodule

// File: tb/tb_axi4_lite_master.sv
// Directed bench for axi4_lite_master; the timeout case runs when
// AXI4L_MASTER_TIMEOUT_EN is defined (TIMEOUT_CYCLES=8 then).
module tb_axi4_lite_master;

`ifdef AXI4L_MASTER_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 256;
`endif

  logic        ACLK, ARESETN;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  int          errors = 0;
  int          checks = 0;

  axi4_lite_master_if #(.ADDRESS(32), .DATA_WIDTH(32)) axi ();

  axi4_lite_master #(.ADDRESS(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
    .m_axi(axi.master)
  );

  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic slave(input logic awr, input logic wr, input logic bv, input logic [1:0] br,
                       input logic arr, input logic rv, input logic [31:0] rd, input logic [1:0] rr);
    axi.M_AWREADY = awr; axi.M_WREADY = wr; axi.M_BVALID = bv; axi.M_BRESP = br;
    axi.M_ARREADY = arr; axi.M_RVALID = rv; axi.M_RDATA = rd; axi.M_RRESP = rr;
  endtask

  task automatic cmd(input logic v, input logic w, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] s);
    cmd_valid = v; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
  endtask

  initial begin
    ARESETN = 1'b0; rsp_ready = 1'b0;
    cmd(0, 0, 0, 0, 0);
    slave(0, 0, 0, 0, 0, 0, 0, 0);
    #12;
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_valids", {axi.M_AWVALID, axi.M_WVALID, axi.M_ARVALID, axi.M_BREADY, axi.M_RREADY}, 0);
    chk("rst_rsp", {rsp_valid, rsp_timeout, rsp_resp, rsp_rdata}, 0);
    chk("rst_addr", {axi.M_AWADDR, axi.M_ARADDR}, 0);
    ARESETN = 1'b1;
    tick();
    chk("idle_cmd_ready", cmd_ready, 1);

    // Write 0x10 / 0xDEADBEEF to a zero-wait slave; RVALID stray-high is ignored.
    slave(1, 1, 1, 2'b00, 0, 1, 32'h1234_5678, 2'b00);
    cmd(1, 1, 32'h10, 32'hDEAD_BEEF, 4'hF);
    tick();                                   // accept N
    cmd(0, 0, 0, 0, 0);
    chk("w1_awvalid_wvalid", {axi.M_AWVALID, axi.M_WVALID}, 2'b11);
    chk("w1_awaddr", axi.M_AWADDR, 32'h10);
    chk("w1_wdata_strb", {axi.M_WDATA, axi.M_WSTRB}, {32'hDEAD_BEEF, 4'hF});
    chk("w1_bready_early", axi.M_BREADY, 0);
    chk("w1_cmd_ready_busy", cmd_ready, 0);
    tick();                                   // N+1 handshake
    chk("w1_valids_drop", {axi.M_AWVALID, axi.M_WVALID}, 2'b00);
    chk("w1_bready", axi.M_BREADY, 1);
    chk("w1_rready_stray", axi.M_RREADY, 0);
    chk("w1_no_rsp_yet", rsp_valid, 0);
    tick();                                   // N+2 B
    chk("w1_rsp_valid", rsp_valid, 1);
    chk("w1_rsp_fields", {rsp_resp, rsp_rdata, rsp_timeout}, {2'b00, 32'h0, 1'b0});
    chk("w1_bready_off", axi.M_BREADY, 0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("w1_rsp_done", {rsp_valid, cmd_ready}, 2'b01);

    // Read 0x13: low address bits forced to zero; data returned 0xDEADBEEF.
    slave(0, 0, 0, 0, 1, 1, 32'hDEAD_BEEF, 2'b00);
    cmd(1, 0, 32'h13, 0, 0);
    tick();
    cmd(0, 0, 0, 0, 0);
    chk("r1_arvalid", {axi.M_ARVALID, axi.M_AWVALID, axi.M_RREADY}, 3'b100);
    chk("r1_araddr", axi.M_ARADDR, 32'h10);
    tick();
    chk("r1_rready", {axi.M_ARVALID, axi.M_RREADY}, 2'b01);
    tick();
    chk("r1_rsp", {rsp_valid, rsp_resp, rsp_rdata}, {1'b1, 2'b00, 32'hDEAD_BEEF});
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // AWREADY three cycles late, WREADY immediate.
    slave(0, 1, 1, 2'b10, 0, 0, 0, 0);
    cmd(1, 1, 32'h44, 32'h0BAD_F00D, 4'h3);
    tick();
    cmd(0, 0, 0, 0, 0);
    chk("w2_both_valid", {axi.M_AWVALID, axi.M_WVALID}, 2'b11);
    tick();
    chk("w2_w_dropped", {axi.M_AWVALID, axi.M_WVALID, axi.M_BREADY}, 3'b100);
    tick();
    chk("w2_aw_held", {axi.M_AWVALID, axi.M_AWADDR, axi.M_BREADY}, {1'b1, 32'h44, 1'b0});
    axi.M_AWREADY = 1'b1;
    axi.M_BVALID  = 1'b0;
    tick();
    chk("w2_aw_done_bready", {axi.M_AWVALID, axi.M_BREADY}, 2'b01);
    axi.M_AWREADY = 1'b0;
    tick();
    chk("w2_wait_b", {axi.M_BREADY, rsp_valid}, 2'b10);
    axi.M_BVALID = 1'b1;
    tick();
    axi.M_BVALID = 1'b0;
    chk("w2_rsp_slverr", {rsp_valid, rsp_resp, rsp_rdata}, {1'b1, 2'b10, 32'h0});

    // Response back-pressure for 5 cycles with a read already pending.
    slave(0, 0, 0, 0, 1, 1, 32'hCAFE_0123, 2'b11);
    cmd(1, 0, 32'h200, 0, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold", {rsp_valid, rsp_resp, rsp_rdata, cmd_ready, axi.M_ARVALID},
          {1'b1, 2'b10, 32'h0, 1'b0, 1'b0});
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("bp_released", {rsp_valid, cmd_ready}, 2'b01);
    tick();                                   // new command accepted here
    cmd(0, 0, 0, 0, 0);
    chk("r2_arvalid", {axi.M_ARVALID, axi.M_ARADDR}, {1'b1, 32'h200});
    tick();
    tick();
    chk("r2_decerr", {rsp_valid, rsp_resp, rsp_rdata, rsp_timeout},
        {1'b1, 2'b11, 32'hCAFE_0123, 1'b0});
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // Reset asserted in the middle of a write.
    slave(0, 0, 0, 0, 0, 0, 0, 0);
    cmd(1, 1, 32'h80, 32'h5555_AAAA, 4'hF);
    tick();
    cmd(0, 0, 0, 0, 0);
    chk("rm_aw_up", {axi.M_AWVALID, axi.M_WVALID}, 2'b11);
    #2 ARESETN = 1'b0;
    #1;
    chk("rm_async_clear", {axi.M_AWVALID, axi.M_WVALID, axi.M_BREADY, cmd_ready}, 0);
    chk("rm_addr_clear", axi.M_AWADDR, 0);
    ARESETN = 1'b1;
    tick();
    axi.M_AWREADY = 1'b1; axi.M_WREADY = 1'b1; axi.M_BVALID = 1'b1;
    tick();
    chk("rm_no_rsp", {rsp_valid, axi.M_AWVALID, axi.M_BREADY, cmd_ready}, 4'b0001);

`ifdef AXI4L_MASTER_TIMEOUT_EN
    // Slave never answers B: timeout after 8 waiting cycles.
    slave(1, 1, 0, 0, 0, 0, 0, 0);
    cmd(1, 1, 32'h20, 32'h1, 4'h1);
    tick();
    cmd(0, 0, 0, 0, 0);
    tick();                                   // enter WRESP
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("to_waiting", {axi.M_BREADY, rsp_valid}, 2'b10);
    end
    tick();
    chk("to_fire", {axi.M_BREADY, rsp_valid, rsp_timeout, rsp_resp, rsp_rdata},
        {1'b0, 1'b1, 1'b1, 2'b10, 32'h0});
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
